// File: rtl/adam_apb_axil_bridge.sv
// APB slave to AXI-Lite master bridge: each APB transfer becomes one AXI-Lite
// write (AW+W, then B) or read (AR, then R), one transaction outstanding at a time.
module adam_apb_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  pause_req,
  output logic                  pause_ack,

  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            pprot,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,

  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [2:0]            aw_prot,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,

  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [2:0]            ar_prot,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_valid,
  output logic                  r_ready
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP, DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;

  // Capture happens whenever psel is seen unpaused, regardless of penable: a
  // master held off by pause is already sitting in its access phase.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, penable, b_resp[0], r_resp[0]};

  logic capture;
  assign capture = (state == IDLE) && !pause_ack && psel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = pwrite ? WR_ADDR : RD_ADDR;
      WR_ADDR: if ((!aw_valid || aw_ready) && (!w_valid || w_ready)) state_next = WR_RESP;
      WR_RESP: if (b_valid && b_ready) state_next = DONE;
      RD_ADDR: if (ar_ready) state_next = RD_RESP;
      RD_RESP: if (r_valid && r_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_ack <= 1'b1;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      b_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      r_ready   <= 1'b0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            addr_q  <= paddr;
            prot_q  <= pprot;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            if (pwrite) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
            end else begin
              ar_valid <= 1'b1;
            end
          end else if (pause_ack != pause_req) begin
            // Pause is only granted or released from IDLE with no capture.
            pause_ack <= pause_req;
          end
        end
        WR_ADDR: begin
          if (aw_ready) aw_valid <= 1'b0;
          if (w_ready)  w_valid  <= 1'b0;
          if (state_next == WR_RESP) b_ready <= 1'b1;
        end
        WR_RESP: begin
          if (b_valid) begin
            pslverr <= b_resp[1];
            prdata  <= '0;
            pready  <= 1'b1;
            b_ready <= 1'b0;
          end
        end
        RD_ADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (r_valid) begin
            prdata  <= r_data;
            pslverr <= r_resp[1];
            pready  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        DONE: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign aw_addr = addr_q;
  assign aw_prot = prot_q;
  assign ar_addr = addr_q;
  assign ar_prot = prot_q;
  assign w_data  = wdata_q;
  assign w_strb  = strb_q;

endmodule

// File: tb/tb_adam_apb_axil_bridge.sv
// Directed bench for adam_apb_axil_bridge: inputs change and outputs are
// checked 1 time unit after each rising edge.
module tb_adam_apb_axil_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_req, pause_ack;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid, aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid, w_ready;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid, ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid, r_ready;

  int n_cmp = 0;
  int n_err = 0;

  adam_apb_axil_bridge dut (
    .clk(clk), .rst(rst),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pause_req = 1'b1;
    paddr = '0; pprot = '0; psel = 0; penable = 0; pwrite = 0; pwdata = '0; pstrb = '0;
    aw_ready = 0; w_ready = 0; b_resp = '0; b_valid = 0;
    ar_ready = 0; r_data = '0; r_resp = '0; r_valid = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_pause_ack", pause_ack, 1);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_valids", {aw_valid, w_valid, ar_valid, b_ready, r_ready}, 0);

    // pause: psel ignored while paused
    psel = 1; pwrite = 0; paddr = 32'h0000_0030; pprot = 3'd5;
    tick(); penable = 1;
    tick(); tick();
    chk("pause_hold_ack", pause_ack, 1);
    chk("pause_hold_ar_valid", ar_valid, 0);
    chk("pause_hold_pready", pready, 0);
    pause_req = 0;
    tick();
    chk("pause_release_ack", pause_ack, 0);
    chk("pause_release_no_capture_yet", ar_valid, 0);
    tick();
    chk("pause_capture_ar_valid", ar_valid, 1);
    chk("pause_capture_ar_addr", ar_addr, 32'h0000_0030);
    chk("pause_capture_ar_prot", ar_prot, 5);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    chk("pause_rd_ar_drop", ar_valid, 0);
    chk("pause_rd_r_ready", r_ready, 1);
    pause_req = 1; r_valid = 1; r_data = 32'h1111_2222; r_resp = 2'b01;
    tick();
    r_valid = 0; psel = 0; penable = 0;
    chk("pause_rd_pready", pready, 1);
    chk("pause_rd_prdata", prdata, 32'h1111_2222);
    chk("pause_rd_pslverr_exokay", pslverr, 0);
    chk("pause_rd_ack_during_done", pause_ack, 0);
    tick();
    chk("pause_rd_pready_fall", pready, 0);
    chk("pause_rd_ack_in_idle", pause_ack, 0);
    tick();
    chk("pause_granted", pause_ack, 1);
    pause_req = 0;
    tick();
    chk("pause_released", pause_ack, 0);

    // test 1: write, slave immediate
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0001_0004; pprot = 3'd2;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF; aw_ready = 1; w_ready = 1;
    tick();
    penable = 1;
    chk("wr1_aw_valid", aw_valid, 1);
    chk("wr1_w_valid", w_valid, 1);
    chk("wr1_aw_addr", aw_addr, 32'h0001_0004);
    chk("wr1_aw_prot", aw_prot, 2);
    chk("wr1_w_data", w_data, 32'hDEAD_BEEF);
    chk("wr1_w_strb", w_strb, 4'hF);
    chk("wr1_pready_c1", pready, 0);
    tick();
    chk("wr1_valids_drop", {aw_valid, w_valid}, 0);
    chk("wr1_b_ready", b_ready, 1);
    chk("wr1_pready_c2", pready, 0);
    b_valid = 1; b_resp = 2'b00;
    tick();
    b_valid = 0; psel = 0; penable = 0; aw_ready = 0; w_ready = 0;
    chk("wr1_pready_c3", pready, 1);
    chk("wr1_pslverr", pslverr, 0);
    chk("wr1_prdata_zero", prdata, 0);
    chk("wr1_b_ready_drop", b_ready, 0);
    tick();
    chk("wr1_pready_c4", pready, 0);

    // test 2: read with stalled AR
    psel = 1; pwrite = 0; paddr = 32'h0002_0000; pprot = 3'd1;
    tick();
    penable = 1;
    chk("rd2_ar_valid_c1", ar_valid, 1);
    chk("rd2_ar_addr_c1", ar_addr, 32'h0002_0000);
    paddr = 32'hFFFF_FFFF;
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("rd2_ar_valid_c%0d", i), ar_valid, 1);
      chk($sformatf("rd2_ar_addr_c%0d", i), ar_addr, 32'h0002_0000);
    end
    ar_ready = 1;
    tick();
    ar_ready = 0;
    chk("rd2_ar_drop", ar_valid, 0);
    chk("rd2_r_ready", r_ready, 1);
    chk("rd2_pready_early", pready, 0);
    r_valid = 1; r_data = 32'h1234_5678; r_resp = 2'b00;
    tick();
    r_valid = 0; psel = 0; penable = 0;
    chk("rd2_pready", pready, 1);
    chk("rd2_prdata", prdata, 32'h1234_5678);
    chk("rd2_pslverr", pslverr, 0);
    tick();
    chk("rd2_pready_fall", pready, 0);
    chk("rd2_prdata_hold", prdata, 32'h1234_5678);

    // test 3: split write handshakes, SLVERR
    psel = 1; pwrite = 1; paddr = 32'h0000_0040; pwdata = 32'h0BAD_F00D; pstrb = 4'h3;
    w_ready = 1; aw_ready = 0;
    tick();
    penable = 1;
    chk("wr3_c1_valids", {aw_valid, w_valid}, 2'b11);
    tick();
    w_ready = 0;
    chk("wr3_c2_w_valid", w_valid, 0);
    chk("wr3_c2_aw_valid", aw_valid, 1);
    chk("wr3_c2_b_ready", b_ready, 0);
    tick();
    chk("wr3_c3_aw_valid", aw_valid, 1);
    chk("wr3_c3_w_strb", w_strb, 4'h3);
    tick();
    chk("wr3_c4_aw_valid", aw_valid, 1);
    chk("wr3_c4_b_ready", b_ready, 0);
    aw_ready = 1;
    tick();
    aw_ready = 0;
    chk("wr3_c5_aw_valid", aw_valid, 0);
    chk("wr3_c5_b_ready", b_ready, 1);
    b_valid = 1; b_resp = 2'b10;
    tick();
    b_valid = 0; psel = 0; penable = 0;
    chk("wr3_pready", pready, 1);
    chk("wr3_pslverr", pslverr, 1);
    chk("wr3_prdata_cleared", prdata, 0);
    tick();
    chk("wr3_pready_fall", pready, 0);
    chk("wr3_pslverr_fall", pslverr, 0);

    // test 4: read DECERR, then back-to-back write
    psel = 1; pwrite = 0; paddr = 32'h0000_0050; ar_ready = 1;
    tick();
    penable = 1;
    chk("rd4_ar_valid", ar_valid, 1);
    tick();
    ar_ready = 0;
    chk("rd4_r_ready", r_ready, 1);
    r_valid = 1; r_resp = 2'b11; r_data = 32'hA5A5_A5A5;
    tick();
    chk("rd4_pready", pready, 1);
    chk("rd4_prdata", prdata, 32'hA5A5_A5A5);
    chk("rd4_pslverr", pslverr, 1);
    r_valid = 0; penable = 0; pwrite = 1; paddr = 32'h0000_0060;
    pwdata = 32'hCAFE_0001; pstrb = 4'hF; aw_ready = 1; w_ready = 1;
    tick();
    chk("b2b_pready_fall", pready, 0);
    chk("b2b_pslverr_fall", pslverr, 0);
    chk("b2b_idle_no_valid", aw_valid, 0);
    tick();
    penable = 1;
    chk("b2b_aw_valid", aw_valid, 1);
    chk("b2b_aw_addr", aw_addr, 32'h0000_0060);
    chk("b2b_w_data", w_data, 32'hCAFE_0001);
    tick();
    aw_ready = 0; w_ready = 0;
    chk("b2b_b_ready", b_ready, 1);
    b_valid = 1; b_resp = 2'b01;
    tick();
    b_valid = 0; psel = 0; penable = 0;
    chk("b2b_pready", pready, 1);
    chk("b2b_pslverr_exokay", pslverr, 0);
    tick();

    // test 6: async reset mid-write
    psel = 1; pwrite = 1; paddr = 32'h0000_0070; aw_ready = 0; w_ready = 0;
    tick();
    chk("rst6_aw_valid_before", aw_valid, 1);
    #2 rst = 1'b1; pause_req = 1'b1;
    #1;
    chk("rst6_aw_valid", aw_valid, 0);
    chk("rst6_w_valid", w_valid, 0);
    chk("rst6_pready", pready, 0);
    chk("rst6_pause_ack", pause_ack, 1);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rst6_idle_no_valid", {aw_valid, w_valid, ar_valid}, 0);
    chk("rst6_idle_paused", pause_ack, 1);
    psel = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
